// File: rtl/avalon_harvard_bridge.sv
// Serialises a Harvard CPU's instruction fetch and data access onto one Avalon-MM master port.
// Each instruction takes FETCH -> DATA -> COMMIT, with a stall watchdog that traps into ERROR.
module avalon_harvard_bridge #(
  parameter int STALL_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        bus_error,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = ($clog2(STALL_LIMIT + 1) > 10) ? $clog2(STALL_LIMIT + 1) : 10;
  localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(STALL_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_next;
  logic             cmd_active;

  assign avm_byteenable = 4'b1111;
  assign state_dbg      = state;

  // Handshake: a command (avm_read or avm_write) is offered while cmd_active is high and is
  // accepted on the first cycle with avm_waitrequest low. Commands derive from the CPU's inputs,
  // which stay stable because clk_enable is low until COMMIT.
  always_comb begin
    state_next     = state;
    stall_cnt_next = '0;
    cmd_active     = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = 32'd0;
    avm_writedata  = 32'd0;
    clk_enable     = 1'b0;
    bus_error      = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        cmd_active  = 1'b1;
        avm_read    = 1'b1;
        avm_address = {instr_address[31:2], 2'b00};
        if (!avm_waitrequest) state_next = DATA;
      end
      DATA: begin
        if (data_write) begin
          cmd_active    = 1'b1;
          avm_write     = 1'b1;
          avm_writedata = data_writedata;
          avm_address   = {data_address[31:2], 2'b00};
        end else if (data_read) begin
          cmd_active  = 1'b1;
          avm_read    = 1'b1;
          avm_address = {data_address[31:2], 2'b00};
        end
        if (!cmd_active || !avm_waitrequest) state_next = COMMIT;
      end
      COMMIT: begin
        clk_enable = 1'b1;
        state_next = active ? FETCH : HALT;
      end
      HALT:    state_next = HALT;
      ERROR:   bus_error  = 1'b1;
      default: state_next = IDLE;
    endcase
    // The command stays up through the final stall cycle; ERROR drops it on the next cycle.
    if (cmd_active && avm_waitrequest) begin
      if (stall_cnt == LAST_STALL) state_next = ERROR;
      else stall_cnt_next = stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      stall_cnt      <= '0;
      instr_readdata <= 32'd0;
      data_readdata  <= 32'd0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      if (state == FETCH && !avm_waitrequest) instr_readdata <= avm_readdata;
      if (state == DATA && avm_read && !avm_waitrequest) data_readdata <= avm_readdata;
    end
  end

endmodule

// File: doc/avalon_harvard_bridge.md
AVALON_HARVARD_BRIDGE -- requirements
Module: avalon_harvard_bridge

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 1023: the maximum number of consecutive waitrequest-high cycles allowed on one bus access before an error is flagged.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port active, input, 1: CPU running flag.
REQ-005 SHALL have port instr_address, input, 32: CPU fetch byte address.
REQ-006 SHALL have port instr_readdata, output, 32: latched instruction word presented to the CPU.
REQ-007 SHALL have port data_address, input, 32: CPU data byte address.
REQ-008 SHALL have ports data_read and data_write, input, 1 each: CPU data strobes.
REQ-009 SHALL have port data_writedata, input, 32: CPU store data.
REQ-010 SHALL have port data_readdata, output, 32: latched load word presented to the CPU.
REQ-011 SHALL have port clk_enable, output, 1: CPU advance strobe.
REQ-012 SHALL have port avm_address, output, 32: Avalon byte address, bits [1:0] always 0.
REQ-013 SHALL have ports avm_read and avm_write, output, 1 each: Avalon commands.
REQ-014 SHALL have port avm_writedata, output, 32: Avalon write data.
REQ-015 SHALL have port avm_byteenable, output, 4: constant 4'b1111.
REQ-016 SHALL have port avm_readdata, input, 32: Avalon read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-017 SHALL have port avm_waitrequest, input, 1: slave stall.
REQ-018 SHALL have port bus_error, output, 1: sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DATA, COMMIT, HALT and ERROR.
REQ-020 IDLE SHALL go to FETCH in the next cycle.
REQ-021 FETCH SHALL drive avm_read=1 and avm_address={instr_address[31:2],2'b00}.
REQ-022 When avm_waitrequest=0 in FETCH, the bridge SHALL capture avm_readdata into instr_readdata and go to DATA.
REQ-023 In DATA, with instr_readdata stable, if data_write=1 the bridge SHALL drive avm_write=1, avm_writedata=data_writedata and avm_address={data_address[31:2],2'b00}.
REQ-024 In DATA, if data_read=1 (and data_write=0), the bridge SHALL drive avm_read=1 at the same address.
REQ-025 In DATA, the access SHALL complete on the first cycle with avm_waitrequest=0; on a read, data_readdata SHALL capture avm_readdata; the FSM SHALL then go to COMMIT.
REQ-026 In DATA, if neither strobe is set, the FSM SHALL go directly to COMMIT with no bus command.
REQ-027 If data_read and data_write are both 1, write SHALL win and no read SHALL be issued.
REQ-028 Commands SHALL be held constant while avm_waitrequest=1, and avm_read and avm_write SHALL never both be 1.
REQ-029 COMMIT SHALL assert clk_enable=1 for exactly one cycle, then go to FETCH if active=1, else to HALT.
REQ-030 clk_enable SHALL be 0 in every state other than COMMIT.
REQ-031 HALT SHALL issue no bus commands, hold clk_enable=0 and remain in HALT until reset.
REQ-032 A 10-bit-minimum counter SHALL count consecutive waitrequest cycles of the current access and clear when the access completes.
REQ-033 When the counter reaches STALL_LIMIT, the bridge SHALL set bus_error=1, deassert the commands and go to ERROR.
REQ-034 ERROR SHALL be terminal until reset, with clk_enable=0 and bus_error held at 1.
REQ-035 Minimum latency per instruction with zero wait states SHALL be 3 cycles (FETCH, DATA, COMMIT), or 3 cycles with DATA issuing no command.
REQ-036 instr_readdata and data_readdata SHALL change only on capture or reset.

Reset
REQ-037 On reset=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL take their reset values: avm_read=0, avm_write=0, clk_enable=0, bus_error=0, instr_readdata=0, data_readdata=0, avm_address=0, avm_writedata=0, stall counter=0.
REQ-038 Reset SHALL take priority over every transition, including mid-access with waitrequest high; the aborted access SHALL NOT be retried.

Verification
REQ-039 Zero-wait ALU instruction: avm_readdata=0x00851021 on fetch, no data strobes -> avm_read pulses one cycle at the fetch address, then clk_enable=1 exactly 2 cycles later.
REQ-040 Store: data_write=1, data_address=0x1006, data_writedata=0xDEADBEEF, waitrequest high 3 cycles -> avm_write held 4 cycles at address 0x1004, clk_enable only after completion.
REQ-041 Load: data_read=1, avm_readdata=0x12345678 on completion -> data_readdata=0x12345678 before clk_enable pulse.
REQ-042 Timeout: waitrequest stuck high with STALL_LIMIT=8 -> bus_error=1 after 8 stall cycles, commands 0, clk_enable stays 0.
REQ-043 Reset asserted mid-fetch with waitrequest=1 -> next cycle avm_read=0, all outputs at reset values, then a fresh FETCH.
REQ-044 active=0 at COMMIT -> HALT entered, no further avm_read or avm_write.
